axi_b_resp_router: RTL and testbench

- Return-path companion to the round-robin write-address arbiter in the N:1 AXI write path.
- Records the binary grant index of every accepted AW transfer in an in-order FIFO.
- Steers each B response from the single slave port back to the master that issued the matching write.
- Pure in-order tracking: no AXI IDs are used. It stalls new AW grants when the outstanding table is full.

---
 rtl/axi_b_resp_router.sv | 122 ++++++++++++
 tb/tb_axi_b_resp_router.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_b_resp_router.sv
`default_nettype none
// ============================================================================
// axi_b_resp_router : in-order B-response return router for an N:1 AXI write path
// Rev 1.0
// ============================================================================
module axi_b_resp_router #(
  parameter int NumMasters = 4,
  parameter int Depth      = 8,
  localparam int IdxWidth  = $clog2(NumMasters),
  localparam int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aw_fire_i,
  input  logic [IdxWidth-1:0]   aw_idx_i,
  output logic                  aw_stall_o,
  input  logic                  s_bvalid_i,
  input  logic [1:0]            s_bresp_i,
  output logic                  s_bready_o,
  output logic [NumMasters-1:0] m_bvalid_o,
  output logic [1:0]            m_bresp_o,
  input  logic [NumMasters-1:0] m_bready_i,
  output logic [CntWidth-1:0]   outstanding_o,
  output logic                  err_o
);

  localparam int PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  logic [IdxWidth-1:0]   mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [CntWidth-1:0]   count;
  logic [7:0]            wdog;
  logic                  err;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  err_set;
  logic                  wdog_trip;
  logic                  aw_idx_ok;
  logic [IdxWidth-1:0]   head;
  logic [NumMasters-1:0] head_sel;

  assign full  = (count == FullCnt);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // One-hot decode of the head entry; an out-of-range index decodes to zero,
  // so such an entry is routed nowhere and never acknowledged.
  always_comb begin
    head_sel  = '0;
    aw_idx_ok = 1'b0;
    for (int i = 0; i < NumMasters; i++) begin
      head_sel[i] = (head == IdxWidth'(i));
      aw_idx_ok   = aw_idx_ok | (aw_idx_i == IdxWidth'(i));
    end
  end

  assign m_bvalid_o    = {NumMasters{s_bvalid_i & ~empty}} & head_sel;
  assign m_bresp_o     = s_bresp_i;
  assign s_bready_o    = ~empty & (|(m_bready_i & head_sel));
  assign aw_stall_o    = full;
  assign outstanding_o = count;
  assign err_o         = err;

  // A pop frees the head slot in the same cycle, so a push into a full table
  // is accepted when it coincides with a pop.
  assign pop  = s_bvalid_i & s_bready_o;
  assign push = aw_fire_i & (~full | pop);

  assign wdog_trip = s_bvalid_i & empty & (wdog == 8'hFF);
  assign err_set   = (aw_fire_i & full & ~pop)
                   | (push & ~aw_idx_ok)
                   | wdog_trip;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= aw_idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wdog   <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase

      // Counts consecutive cycles of a B offered with nothing outstanding;
      // saturates once it has tripped.
      if (!(s_bvalid_i && empty)) begin
        wdog <= '0;
      end else if (wdog != 8'hFF) begin
        wdog <= wdog + 8'd1;
      end

      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_b_resp_router.sv
`default_nettype none
// Testbench for axi_b_resp_router: queue-based reference model plus directed literal checks.
module tb_axi_b_resp_router;

  logic       clk;
  logic       rst;
  logic       aw_fire;
  logic [1:0] aw_idx;
  logic       aw_stall;
  logic       s_bvalid;
  logic [1:0] s_bresp;
  logic       s_bready;
  logic [3:0] m_bvalid;
  logic [1:0] m_bresp;
  logic [3:0] m_bready;
  logic [3:0] outstanding;
  logic       err;

  // Second instance: non-power-of-two master count and depth
  logic       b_aw_fire;
  logic [1:0] b_aw_idx;
  logic       b_aw_stall;
  logic       b_s_bvalid;
  logic [1:0] b_s_bresp;
  logic       b_s_bready;
  logic [2:0] b_m_bvalid;
  logic [1:0] b_m_bresp;
  logic [2:0] b_m_bready;
  logic [2:0] b_outstanding;
  logic       b_err;

  int checks = 0;
  int errors = 0;

  axi_b_resp_router #(.NumMasters(4), .Depth(8)) dut (
    .clk(clk), .rst(rst),
    .aw_fire_i(aw_fire), .aw_idx_i(aw_idx), .aw_stall_o(aw_stall),
    .s_bvalid_i(s_bvalid), .s_bresp_i(s_bresp), .s_bready_o(s_bready),
    .m_bvalid_o(m_bvalid), .m_bresp_o(m_bresp), .m_bready_i(m_bready),
    .outstanding_o(outstanding), .err_o(err)
  );

  axi_b_resp_router #(.NumMasters(3), .Depth(5)) dut_b (
    .clk(clk), .rst(rst),
    .aw_fire_i(b_aw_fire), .aw_idx_i(b_aw_idx), .aw_stall_o(b_aw_stall),
    .s_bvalid_i(b_s_bvalid), .s_bresp_i(b_s_bresp), .s_bready_o(b_s_bready),
    .m_bvalid_o(b_m_bvalid), .m_bresp_o(b_m_bresp), .m_bready_i(b_m_bready),
    .outstanding_o(b_outstanding), .err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         mq[$];
  bit         m_err;
  int         m_wd;
  int         sz;
  int         hd;
  bit         emp;
  bit         ful;
  bit         e_bready;
  bit         m_pop;
  bit         m_push;
  logic [3:0] e_bvalid;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      m_wd  = 0;
    end else begin
      sz       = mq.size();
      emp      = (sz == 0);
      ful      = (sz == 8);
      hd       = emp ? 0 : mq[0];
      e_bvalid = (s_bvalid && !emp && hd < 4) ? 4'(1 << hd) : 4'd0;
      e_bready = !emp && hd < 4 && m_bready[hd];

      chk("m_bvalid", m_bvalid, e_bvalid);
      chk("s_bready", s_bready, e_bready);
      chk("m_bresp", m_bresp, s_bresp);
      chk("outstanding", outstanding, sz);
      chk("aw_stall", aw_stall, ful);
      chk("err", err, m_err);

      m_pop  = s_bvalid && e_bready;
      m_push = aw_fire && (!ful || m_pop);
      if (aw_fire && ful && !m_pop) m_err = 1'b1;
      if (m_push && aw_idx >= 4) m_err = 1'b1;
      if (s_bvalid && emp) begin
        m_wd++;
        if (m_wd >= 256) m_err = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(int'(aw_idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    aw_fire = 0; aw_idx = 0; s_bvalid = 0; s_bresp = 0; m_bready = 0;
    b_aw_fire = 0; b_aw_idx = 0; b_s_bvalid = 0; b_s_bresp = 0; b_m_bready = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset outstanding", outstanding, 0);
    chk("reset aw_stall", aw_stall, 0);
    chk("reset m_bvalid", m_bvalid, 0);
    chk("reset s_bready", s_bready, 0);
    chk("reset err", err, 0);

    // In-order routing of 2,0,3
    aw_fire = 1; aw_idx = 2; step();
    aw_idx = 0; step();
    aw_idx = 3; step();
    aw_fire = 0;
    chk("three pushed", outstanding, 3);
    s_bvalid = 1; m_bready = 4'hF; s_bresp = 2'd0; #1;
    chk("route 1st", m_bvalid, 4'b0100);
    chk("resp 1st", m_bresp, 2'd0);
    step(); s_bresp = 2'd2; #1;
    chk("route 2nd", m_bvalid, 4'b0001);
    chk("resp 2nd", m_bresp, 2'd2);
    step(); s_bresp = 2'd1; #1;
    chk("route 3rd", m_bvalid, 4'b1000);
    chk("resp 3rd", m_bresp, 2'd1);
    step(); s_bvalid = 0;
    chk("drained", outstanding, 0);

    // Backpressure on master 1
    aw_fire = 1; aw_idx = 1; step(); aw_fire = 0;
    s_bvalid = 1; m_bready = 4'b1101;
    repeat (5) begin
      #1;
      chk("bp m_bvalid", m_bvalid, 4'b0010);
      chk("bp s_bready", s_bready, 0);
      chk("bp outstanding", outstanding, 1);
      step();
    end
    m_bready = 4'hF; #1;
    chk("bp released", s_bready, 1);
    step(); s_bvalid = 0;
    chk("bp popped", outstanding, 0);

    // Fill, concurrent push+pop with wrap, overflow
    for (int i = 0; i < 8; i++) begin
      aw_fire = 1; aw_idx = 2'(i % 4); step();
    end
    aw_fire = 0;
    chk("full stall", aw_stall, 1);
    chk("full count", outstanding, 8);
    s_bvalid = 1; m_bready = 4'hF;
    for (int i = 0; i < 20; i++) begin
      aw_fire = 1; aw_idx = 2'($urandom_range(0, 3)); s_bresp = 2'($urandom);
      step();
      if (i == 0) begin
        chk("push+pop full count", outstanding, 8);
        chk("push+pop full err", err, 0);
      end
    end
    s_bvalid = 0; aw_fire = 1; step(); aw_fire = 0;
    chk("overflow err", err, 1);
    chk("overflow count", outstanding, 8);
    s_bvalid = 1; repeat (8) step(); s_bvalid = 0;
    chk("wrap drained", outstanding, 0);

    // Empty-B watchdog
    do_reset();
    s_bvalid = 1;
    repeat (255) step();
    chk("wdog 255", err, 0);
    step();
    chk("wdog 256", err, 1);
    do_reset();
    s_bvalid = 1; m_bready = 4'hF;
    repeat (9) step();
    aw_fire = 1; aw_idx = 2; #1;
    chk("no bypass", m_bvalid, 0);
    step(); aw_fire = 0; #1;
    chk("routed next cycle", m_bvalid, 4'b0100);
    step(); s_bvalid = 0;
    chk("wdog push err", err, 0);

    // Randomized traffic with occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int aw_bias;
      int b_bias;
      aw_bias = ((n / 500) % 2 == 0) ? 3 : 1;
      b_bias  = ((n / 500) % 2 == 0) ? 1 : 3;
      rst      = ($urandom_range(0, 399) == 0);
      aw_fire  = ($urandom_range(0, 3) < aw_bias) && (!aw_stall || $urandom_range(0, 7) == 0);
      aw_idx   = 2'($urandom_range(0, 3));
      s_bvalid = ($urandom_range(0, 3) < b_bias);
      s_bresp  = 2'($urandom);
      m_bready = 4'($urandom);
      step();
    end
    rst = 0;

    // Out-of-range index on a 3-master, depth-5 instance
    do_reset();
    b_aw_fire = 1; b_aw_idx = 2'd3; step();
    chk("bad idx err", b_err, 1);
    b_aw_idx = 2'd1; step(); b_aw_fire = 0;
    chk("bad idx stored", b_outstanding, 2);
    b_s_bvalid = 1; b_m_bready = 3'b111; #1;
    chk("bad head m_bvalid", b_m_bvalid, 3'b000);
    chk("bad head s_bready", b_s_bready, 0);
    step();
    chk("bad head no pop", b_outstanding, 2);
    b_s_bvalid = 0;
    b_aw_fire = 1; b_aw_idx = 2'd2; repeat (3) step(); b_aw_fire = 0;
    chk("depth5 stall", b_aw_stall, 1);
    chk("depth5 count", b_outstanding, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
